// File: rtl/display_scan_scheduler.sv
// Time-multiplexed 7-segment scan driver for common-anode digits with per-slot
// anti-ghosting blank time, a once-per-frame input snapshot, hex decode and leading-zero suppression.
module display_scan_scheduler #(
  parameter int NUM_DIGITS   = 4,
  parameter int PRESCALE     = 50000,
  parameter int BLANK_CYCLES = 16
) (
  input  logic                      clk,
  input  logic                      btn,
  input  logic                      en,
  input  logic [4*NUM_DIGITS-1:0]   digits,
  input  logic [NUM_DIGITS-1:0]     dp_en,
  input  logic                      lz_en,
  output logic [6:0]                seg,
  output logic                      dp,
  output logic [NUM_DIGITS-1:0]     an,
  output logic                      frame_start
);

  localparam int CNT_W = $clog2(PRESCALE);
  localparam int IDX_W = $clog2(NUM_DIGITS);

  typedef enum logic [1:0] {
    PH_IDLE,
    PH_BLANK,
    PH_DRIVE
  } phase_t;

  logic [CNT_W-1:0]      cnt;
  logic [IDX_W-1:0]      idx;
  logic [3:0]            snap [NUM_DIGITS];
  logic [NUM_DIGITS-1:0] snap_dp;

  phase_t                phase;
  logic                  cnt_wrap;
  logic                  idx_wrap;
  logic                  frame_edge;
  logic                  zero_run;
  logic [NUM_DIGITS-1:0] suppress;
  logic [6:0]            seg_nxt;
  logic                  dp_nxt;
  logic [NUM_DIGITS-1:0] an_nxt;

  function automatic logic [6:0] hex7(input logic [3:0] h);
    case (h)
      4'h0: hex7 = 7'h40;
      4'h1: hex7 = 7'h79;
      4'h2: hex7 = 7'h24;
      4'h3: hex7 = 7'h30;
      4'h4: hex7 = 7'h19;
      4'h5: hex7 = 7'h12;
      4'h6: hex7 = 7'h02;
      4'h7: hex7 = 7'h78;
      4'h8: hex7 = 7'h00;
      4'h9: hex7 = 7'h10;
      4'hA: hex7 = 7'h08;
      4'hB: hex7 = 7'h03;
      4'hC: hex7 = 7'h46;
      4'hD: hex7 = 7'h21;
      4'hE: hex7 = 7'h06;
      default: hex7 = 7'h0E;
    endcase
  endfunction

  always_comb begin
    cnt_wrap   = (cnt == CNT_W'(PRESCALE - 1));
    idx_wrap   = (idx == IDX_W'(NUM_DIGITS - 1));
    frame_edge = en && (cnt == '0) && (idx == '0);

    if (!en)
      phase = PH_IDLE;
    else if (cnt < CNT_W'(BLANK_CYCLES))
      phase = PH_BLANK;
    else
      phase = PH_DRIVE;

    // A digit is blank when it and every more-significant nibble is zero; digit 0 always shows.
    zero_run = 1'b1;
    suppress = '0;
    for (int unsigned k = 0; k < NUM_DIGITS; k++) begin
      zero_run = zero_run & (snap[IDX_W'(NUM_DIGITS - 1 - k)] == 4'h0);
      suppress[IDX_W'(NUM_DIGITS - 1 - k)] = lz_en & zero_run & (k != NUM_DIGITS - 1);
    end

    an_nxt  = '1;
    seg_nxt = 7'h7F;
    dp_nxt  = 1'b1;
    if (phase == PH_DRIVE) begin
      an_nxt  = ~(NUM_DIGITS'(1) << idx);
      seg_nxt = suppress[idx] ? 7'h7F : hex7(snap[idx]);
      dp_nxt  = ~snap_dp[idx];
    end
  end

  always_ff @(posedge clk) begin
    if (btn) begin
      cnt         <= '0;
      idx         <= '0;
      seg         <= 7'h7F;
      dp          <= 1'b1;
      an          <= '1;
      frame_start <= 1'b0;
      snap_dp     <= '0;
      for (int unsigned i = 0; i < NUM_DIGITS; i++)
        snap[IDX_W'(i)] <= '0;
    end else begin
      seg         <= seg_nxt;
      dp          <= dp_nxt;
      an          <= an_nxt;
      frame_start <= frame_edge;
      if (en) begin
        cnt <= cnt_wrap ? '0 : cnt + 1'b1;
        if (cnt_wrap)
          idx <= idx_wrap ? '0 : idx + 1'b1;
      end
      if (frame_edge) begin
        snap_dp <= dp_en;
        for (int unsigned i = 0; i < NUM_DIGITS; i++)
          snap[IDX_W'(i)] <= digits[4*i +: 4];
      end
    end
  end

endmodule

// File: tb/tb_display_scan_scheduler.sv
// Directed bench for display_scan_scheduler with NUM_DIGITS=4, PRESCALE=8, BLANK_CYCLES=2.
module tb_display_scan_scheduler;

  logic        clk = 1'b0;
  logic        btn = 1'b1;
  logic        en = 1'b1;
  logic [15:0] digits = '0;
  logic [3:0]  dp_en = '0;
  logic        lz_en = 1'b0;
  logic [6:0]  seg;
  logic        dp;
  logic [3:0]  an;
  logic        frame_start;

  int checks = 0;
  int errors = 0;

  display_scan_scheduler #(
    .NUM_DIGITS(4),
    .PRESCALE(8),
    .BLANK_CYCLES(2)
  ) dut (
    .clk(clk),
    .btn(btn),
    .en(en),
    .digits(digits),
    .dp_en(dp_en),
    .lz_en(lz_en),
    .seg(seg),
    .dp(dp),
    .an(an),
    .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0]     digits;
    logic [3:0]      dp_en;
    logic            lz_en;
    logic [3:0][6:0] seg_exp;  // index = digit number
  } vec_t;

  vec_t tbl [7];

  localparam logic [12:0] BLANK_OUT = {4'hF, 7'h7F, 1'b1, 1'b0};

  task automatic compare(input string name, input int k, input logic [12:0] got, input logic [12:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s k=%0d: got an=%b seg=%h dp=%b fs=%b, expected an=%b seg=%h dp=%b fs=%b",
               name, k, got[12:9], got[8:2], got[1], got[0], exp[12:9], exp[8:2], exp[1], exp[0]);
    end
  endtask

  // Sample after posedge P(k0)..P(k0+n-1), where P0 is the first frame edge after reset release.
  task automatic check_cycles(input string name, input int k0, input int n,
                              input logic [3:0][6:0] segs, input logic [3:0] dpe);
    int p, d, c;
    logic [12:0] exp;
    for (int j = 0; j < n; j++) begin
      @(posedge clk);
      #1;
      p = (k0 + j) % 32;
      d = p / 8;
      c = p % 8;
      if (c < 2)
        exp = {4'hF, 7'h7F, 1'b1, (p == 0)};
      else
        exp = {~(4'b0001 << d), segs[d], ~dpe[d], 1'b0};
      compare(name, k0 + j, {an, seg, dp, frame_start}, exp);
    end
  endtask

  task automatic do_reset(input string name, input int n);
    btn = 1'b1;
    for (int j = 0; j < n; j++) begin
      @(posedge clk);
      #1;
      compare(name, j, {an, seg, dp, frame_start}, BLANK_OUT);
    end
    btn = 1'b0;
  endtask

  task automatic apply(input int i);
    digits = tbl[i].digits;
    dp_en  = tbl[i].dp_en;
    lz_en  = tbl[i].lz_en;
  endtask

  initial begin
    tbl[0] = '{16'h1234, 4'b0000, 1'b0, {7'h79, 7'h24, 7'h30, 7'h19}};
    tbl[1] = '{16'h0050, 4'b0010, 1'b1, {7'h7F, 7'h7F, 7'h12, 7'h40}};
    tbl[2] = '{16'h0050, 4'b0010, 1'b0, {7'h40, 7'h40, 7'h12, 7'h40}};
    tbl[3] = '{16'hABCD, 4'b1111, 1'b1, {7'h08, 7'h03, 7'h46, 7'h21}};
    tbl[4] = '{16'h0000, 4'b0000, 1'b1, {7'h7F, 7'h7F, 7'h7F, 7'h40}};
    tbl[5] = '{16'hEF89, 4'b1000, 1'b1, {7'h06, 7'h0E, 7'h00, 7'h10}};
    tbl[6] = '{16'h0600, 4'b0001, 1'b1, {7'h7F, 7'h02, 7'h40, 7'h40}};

    @(negedge clk);
    do_reset("reset_hold", 5);

    for (int i = 0; i < 7; i++) begin
      apply(i);
      if (i != 0) do_reset("reset_vec", 2);
      check_cycles($sformatf("scan_vec%0d", i), 0, 64, tbl[i].seg_exp, tbl[i].dp_en);
    end

    // Mid-frame input change must not reach the display until the next frame edge.
    apply(0);
    do_reset("reset_coh", 2);
    check_cycles("coh_pre", 0, 19, tbl[0].seg_exp, tbl[0].dp_en);
    digits = 16'hABCD;
    check_cycles("coh_hold", 19, 13, tbl[0].seg_exp, tbl[0].dp_en);
    check_cycles("coh_next", 32, 32, {7'h08, 7'h03, 7'h46, 7'h21}, 4'b0000);

    // Reset in the middle of digit 2 drive, then restart from digit 0.
    apply(0);
    do_reset("reset_mid0", 2);
    check_cycles("mid_pre", 0, 20, tbl[0].seg_exp, tbl[0].dp_en);
    do_reset("reset_mid", 1);
    check_cycles("mid_restart", 0, 32, tbl[0].seg_exp, tbl[0].dp_en);

    // Freeze with cnt=4 of digit 1; resume picks up the same position.
    apply(0);
    do_reset("reset_en", 2);
    check_cycles("en_pre", 0, 12, tbl[0].seg_exp, tbl[0].dp_en);
    en = 1'b0;
    for (int j = 0; j < 20; j++) begin
      @(posedge clk);
      #1;
      compare("en_off", j, {an, seg, dp, frame_start}, BLANK_OUT);
    end
    en = 1'b1;
    check_cycles("en_resume", 12, 52, tbl[0].seg_exp, tbl[0].dp_en);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
